sect233r1_pt_chk: RTL
=====================

SECT233R1_PT_CHK -- requirements
Module: sect233r1_pt_chk

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request; samples x, y.
REQ-004 SHALL have port: x  input  233  affine x of candidate point, normally the x output of sect233r1_pt_mul.
REQ-005 SHALL have port: y  input  233  affine y of candidate point, normally the y output of sect233r1_pt_mul.
REQ-006 SHALL have port: busy  output  1  high from accepted start until done.
REQ-007 SHALL have port: done  output  1  one-cycle pulse; result ready.
REQ-008 SHALL have port: valid  output  1  1 = point on curve; held until next accepted start or rst.
REQ-009 SHALL have port: inf  output  1  1 = input classified as point at infinity; held like valid.

Function
REQ-010 SHALL test y^2 + x*y == x^3 + x^2 + b over GF(2^233), f(z)=z^233+z^74+1, b = sect233r1 constant per SEC 2.
REQ-011 SHALL evaluate as lhs = y*(y^x), rhs = (x*x)*(x^1) ^ b; three field multiplications, one shared multiplier.
REQ-012 Multiplier SHALL be bit-serial MSB-first shift-and-add with interleaved reduction by f; exactly 233 cycles per product.
REQ-013 FSM states: IDLE, MUL1 (s=x*x), MUL2 (r=s*(x^1)), MUL3 (l=y*(y^x)), CMP, FIN.
REQ-014 IDLE->MUL1 on start=1; MULn->next after 233 cycles; CMP->FIN after 1 cycle; FIN->IDLE after 1 cycle.
REQ-015 x, y SHALL be latched at the accepting edge; input changes afterward have no effect.
REQ-016 Latency: with start sampled at edge 0, done SHALL be high in the cycle following edge 700 (3*233+1).
REQ-017 done SHALL be high only in FIN; busy SHALL be high in MUL1..CMP, low in IDLE and FIN.
REQ-018 valid SHALL be (l == r^b) registered on CMP->FIN; inf SHALL be 0 for all non-early-out results.
REQ-019 start while busy=1 SHALL be ignored (no queueing); start in FIN SHALL be ignored.
REQ-020 valid and inf SHALL clear to 0 on each accepted start.
REQ-021 Arithmetic SHALL be pure XOR/shift; no carries; intermediate registers exactly 233 bits.

Reset
REQ-022 rst=1 at any clock edge SHALL force IDLE and clear busy, done, valid, inf, all datapath registers to 0.
REQ-023 rst mid-operation SHALL abort the check without any done pulse; start coincident with rst SHALL be ignored.
REQ-024 First start SHALL be accepted on the first edge with rst=0.

Configuration
REQ-025 Macro SECT233R1_PT_CHK_INF_EN SHALL select infinity early-out.
REQ-026 With SECT233R1_PT_CHK_INF_EN defined: accepted start with x==0 and y==0 SHALL go IDLE->CMP->FIN, done high after edge 2, valid=1, inf=1.
REQ-027 Without it: (0,0) SHALL take the full 700-cycle path, result valid=0, inf=0; inf port present and constant 0.

Verification
REQ-028 x=Gx=0FAC9DFCBAC8313BB2139F1BB755FEF65BC391F8B36F8F8EB7371FD558B, y=Gy=1006A08A41903350678E58528BEBF8A0BEFF867A7CA36716F7E01F81052 -> done after edge 700, valid=1, inf=0.
REQ-029 x=Gx, y=Gy^1 -> done after edge 700, valid=0, inf=0.
REQ-030 x=0, y=0 -> macro on: done after edge 2, valid=1, inf=1; macro off: done after edge 700, valid=0, inf=0.
REQ-031 start with G, second start with x=Gx,y=Gy^1 at edge 100 -> ignored; single done after edge 700, valid=1.
REQ-032 start with G, rst=1 at edge 300 -> busy=0, no done, valid=0; new start with G after rst -> valid=1 after 700 cycles.
REQ-033 All outputs of sect233r1_pt_mul from its testcase files fed in via start -> every result valid=1.

Source files
------------

// File: rtl/sect233r1_pt_chk.sv
// sect233r1_pt_chk: checks that an affine point (x, y) lies on sect233r1,
// y^2 + x*y == x^3 + x^2 + b over GF(2^233), f(z) = z^233 + z^74 + 1.
// One bit-serial MSB-first multiplier (233 cycles/product) is shared by
// s = x*x, r = s*(x^1), l = y*(y^x); the result is valid = (l == r^b).
// Optional build macro SECT233R1_PT_CHK_INF_EN adds an early-out that
// classifies (0,0) as the point at infinity.
module sect233r1_pt_chk (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [232:0] x,
  input  logic [232:0] y,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic         inf
);

  localparam int unsigned W    = 233;
  localparam int unsigned CW   = 8;
  localparam int unsigned LAST = W - 1;

  localparam logic [239:0] B_WIDE =
    240'h0066_647EDE6C_332C7F8C_0923BB58_213B333B_20E9CE42_81FE115F_7D8F90AD;
  localparam logic [W-1:0] B   = B_WIDE[W-1:0];
  // z^233 folds back onto z^74 + 1
  localparam logic [W-1:0] RED = {158'd0, 1'b1, 73'd0, 1'b1};

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, CMP, FIN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [W-1:0]  s_q, s_d, r_q, r_d;
  logic [W-1:0]  acc_q, acc_d, opb_q, opb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_d, done_d, valid_d, inf_d;
  logic [W-1:0]  op_a, acc_sh, acc_nx;
`ifdef SECT233R1_PT_CHK_INF_EN
  logic          zero_q, zero_d;
`endif

  // One multiplier step: acc <- acc*z mod f, plus op_a if current bit of opb is set
  always_comb begin
    op_a = '0;
    case (state_q)
      MUL1:    op_a = x_q;
      MUL2:    op_a = s_q;
      MUL3:    op_a = y_q;
      default: op_a = '0;
    endcase
    acc_sh = {acc_q[W-2:0], 1'b0} ^ (acc_q[W-1] ? RED : '0);
    acc_nx = acc_sh ^ (opb_q[W-1] ? op_a : '0);
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    s_d     = s_q;
    r_d     = r_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    valid_d = valid;
    inf_d   = inf;
`ifdef SECT233R1_PT_CHK_INF_EN
    zero_d  = zero_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          acc_d   = '0;
          opb_d   = x;
          cnt_d   = '0;
          valid_d = 1'b0;
          inf_d   = 1'b0;
          state_d = MUL1;
`ifdef SECT233R1_PT_CHK_INF_EN
          zero_d  = (x == '0) && (y == '0);
          if ((x == '0) && (y == '0)) state_d = CMP;
`endif
        end
      end
      MUL1, MUL2, MUL3: begin
        acc_d = acc_nx;
        opb_d = opb_q << 1;
        cnt_d = CW'(cnt_q + CW'(1));
        if (cnt_q == CW'(LAST)) begin
          cnt_d = '0;
          case (state_q)
            MUL1: begin
              s_d     = acc_nx;
              acc_d   = '0;
              opb_d   = x_q ^ W'(1);
              state_d = MUL2;
            end
            MUL2: begin
              r_d     = acc_nx;
              acc_d   = '0;
              opb_d   = y_q ^ x_q;
              state_d = MUL3;
            end
            default: state_d = CMP;
          endcase
        end
      end
      CMP: begin
`ifdef SECT233R1_PT_CHK_INF_EN
        // early-out dwells two cycles so done lands after edge 2
        if (zero_q) begin
          if (cnt_q == '0) begin
            cnt_d = CW'(1);
          end else begin
            cnt_d   = '0;
            valid_d = 1'b1;
            inf_d   = 1'b1;
            state_d = FIN;
          end
        end else begin
          valid_d = (acc_q == (r_q ^ B));
          inf_d   = 1'b0;
          state_d = FIN;
        end
`else
        valid_d = (acc_q == (r_q ^ B));
        inf_d   = 1'b0;
        state_d = FIN;
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MUL1) || (state_d == MUL2) ||
             (state_d == MUL3) || (state_d == CMP);
    done_d = (state_d == FIN);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      inf     <= 1'b0;
`ifdef SECT233R1_PT_CHK_INF_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      s_q     <= s_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      valid   <= valid_d;
      inf     <= inf_d;
`ifdef SECT233R1_PT_CHK_INF_EN
      zero_q  <= zero_d;
`endif
    end
  end

endmodule
